// File: rtl/br_resolve_sched_pkg.sv
// Shared branch-resolution definitions: state encodings, tag count and pending-entry record.
package br_resolve_sched_pkg;

    localparam int BR_MASK_W  = 4;
    localparam int BR_STATE_W = 2;

    typedef enum logic [BR_STATE_W-1:0] {
        BR_NO_BRANCH  = 2'd0,
        BR_PR_CORRECT = 2'd1,
        BR_PR_WRONG   = 2'd2
    } br_state_e;

    typedef struct packed {
        logic                 vld;
        logic                 wrong;
        logic [BR_MASK_W-1:0] dep;
    } br_pend_ent_t;

endpackage

// File: rtl/br_oldest_sel.sv
// Picks the oldest candidate tag: one whose dep mask names no other candidate; lowest index on ties.
module br_oldest_sel #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]        cand,
    input  logic [N-1:0][N-1:0] dep,
    output logic                any,
    output logic [IDX_W-1:0]    idx
);

    logic [N-1:0] qual;
    logic         found;

    always_comb begin
        qual  = '0;
        idx   = '0;
        found = 1'b0;
        any   = |cand;
        for (int unsigned i = 0; i < N; i++) begin
            qual[i] = cand[i] && ((dep[i] & cand & ~(N'(1) << i)) == '0);
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (qual[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
        // A cyclic dep pattern cannot arise legally; still issue something rather than stall.
        for (int unsigned i = 0; i < N; i++) begin
            if (cand[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/br_resolve_sched.sv
// Branch resolution scheduler: tag-indexed pending table, one issue per cycle, mispredicts first.
// Optional macro BR_SCHED_BYPASS_EN: empty-table arrivals issue in their arrival cycle.
module br_resolve_sched #(
    parameter int NUM_BRU    = 2,
    parameter int BR_MASK_W  = br_resolve_sched_pkg::BR_MASK_W,
    parameter int BR_STATE_W = br_resolve_sched_pkg::BR_STATE_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_BRU-1:0]                bru_valid_i,
    input  logic [NUM_BRU-1:0][BR_MASK_W-1:0] bru_br_bit_i,
    input  logic [NUM_BRU-1:0][BR_MASK_W-1:0] bru_dep_mask_i,
    input  logic [NUM_BRU-1:0]                bru_wrong_i,
    output logic [BR_STATE_W-1:0]             br_state_o,
    output logic [BR_MASK_W-1:0]              br_dep_mask_o,
    output logic                              recover_o,
    output logic [$clog2(BR_MASK_W):0]        pend_cnt_o
);

    import br_resolve_sched_pkg::*;

    localparam int IDX_W = $clog2(BR_MASK_W);
    localparam int CNT_W = $clog2(BR_MASK_W) + 1;

    br_pend_ent_t tbl     [BR_MASK_W];
    br_pend_ent_t tbl_nxt [BR_MASK_W];
    logic [CNT_W-1:0] cnt_nxt;

    logic [BR_MASK_W-1:0]                vld_vec;
    logic [BR_MASK_W-1:0]                wrong_cand;
    logic [BR_MASK_W-1:0][BR_MASK_W-1:0] dep_vec;
    logic                                w_any;
    logic [IDX_W-1:0]                    w_idx;

    logic                 iss_vld;
    logic                 iss_wrong;
    logic [BR_MASK_W-1:0] iss_tag;
    logic [BR_MASK_W-1:0] iss_mask;
    logic [NUM_BRU-1:0]   byp_sel;
    logic                 keep;

    always_comb begin
        vld_vec    = '0;
        wrong_cand = '0;
        dep_vec    = '0;
        for (int unsigned t = 0; t < BR_MASK_W; t++) begin
            vld_vec[t]    = tbl[t].vld;
            wrong_cand[t] = tbl[t].vld & tbl[t].wrong;
            dep_vec[t]    = tbl[t].dep;
        end
    end

    br_oldest_sel #(.N(BR_MASK_W), .IDX_W(IDX_W)) u_oldest (
        .cand (wrong_cand),
        .dep  (dep_vec),
        .any  (w_any),
        .idx  (w_idx)
    );

    always_comb begin
        iss_vld   = 1'b0;
        iss_wrong = 1'b0;
        iss_tag   = '0;
        iss_mask  = '0;
        byp_sel   = '0;
        if (!rst) begin
            iss_vld = 1'b0;
        end else if (w_any) begin
            iss_vld   = 1'b1;
            iss_wrong = 1'b1;
            iss_tag   = BR_MASK_W'(1) << w_idx;
            iss_mask  = dep_vec[w_idx] | iss_tag;
        end else if (|vld_vec) begin
            for (int unsigned t = 0; t < BR_MASK_W; t++) begin
                if (vld_vec[t] && !iss_vld) begin
                    iss_vld  = 1'b1;
                    iss_tag  = BR_MASK_W'(1) << t;
                    iss_mask = dep_vec[t] | iss_tag;
                end
            end
        end else begin
`ifdef BR_SCHED_BYPASS_EN
            for (int unsigned b = 0; b < NUM_BRU; b++) begin
                if (bru_valid_i[b] && !iss_vld) begin
                    iss_vld    = 1'b1;
                    iss_wrong  = bru_wrong_i[b];
                    iss_tag    = bru_br_bit_i[b];
                    iss_mask   = bru_dep_mask_i[b] | bru_br_bit_i[b];
                    byp_sel[b] = 1'b1;
                end
            end
`else
            iss_vld = 1'b0;
`endif
        end
    end

    assign br_state_o    = !iss_vld ? BR_STATE_W'(BR_NO_BRANCH)
                         : iss_wrong ? BR_STATE_W'(BR_PR_WRONG) : BR_STATE_W'(BR_PR_CORRECT);
    assign br_dep_mask_o = iss_mask;
    assign recover_o     = iss_vld & iss_wrong;

    // Issued tag is retired, its dependents squashed on a mispredict, and its bit dropped everywhere else.
    always_comb begin
        keep    = 1'b0;
        cnt_nxt = '0;
        for (int unsigned t = 0; t < BR_MASK_W; t++) begin
            tbl_nxt[t]     = tbl[t];
            tbl_nxt[t].dep = tbl[t].dep & ~iss_tag;
            if (iss_tag[t] || (iss_wrong && ((tbl[t].dep & iss_tag) != '0))) begin
                tbl_nxt[t] = '0;
            end
        end
        for (int unsigned b = 0; b < NUM_BRU; b++) begin
            keep = bru_valid_i[b] && !byp_sel[b]
                && !(iss_wrong && ((bru_dep_mask_i[b] & iss_tag) != '0));
            for (int unsigned t = 0; t < BR_MASK_W; t++) begin
                if (keep && bru_br_bit_i[b][t]) begin
                    tbl_nxt[t].vld   = 1'b1;
                    tbl_nxt[t].wrong = bru_wrong_i[b];
                    tbl_nxt[t].dep   = bru_dep_mask_i[b] & ~iss_tag;
                end
            end
        end
        for (int unsigned t = 0; t < BR_MASK_W; t++) begin
            cnt_nxt = cnt_nxt + CNT_W'(tbl_nxt[t].vld);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned t = 0; t < BR_MASK_W; t++) begin
                tbl[t] <= '0;
            end
            pend_cnt_o <= '0;
        end else begin
            for (int unsigned t = 0; t < BR_MASK_W; t++) begin
                tbl[t] <= tbl_nxt[t];
            end
            pend_cnt_o <= cnt_nxt;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned b = 0; b < NUM_BRU; b++) begin
                for (int unsigned t = 0; t < BR_MASK_W; t++) begin
                    if (bru_valid_i[b] && bru_br_bit_i[b][t]) begin
                        assert (!tbl[t].vld)
                            else $error("arrival on tag %0d already pending", t);
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_br_resolve_sched.sv
// Directed vector bench for br_resolve_sched; expectations are selected per BR_SCHED_BYPASS_EN.
module tb_br_resolve_sched;

    import br_resolve_sched_pkg::*;

    localparam int NB = 2;
    localparam int MW = 4;
`ifdef BR_SCHED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NB-1:0]       bru_valid_i;
    logic [NB-1:0][MW-1:0] bru_br_bit_i;
    logic [NB-1:0][MW-1:0] bru_dep_mask_i;
    logic [NB-1:0]       bru_wrong_i;
    logic [1:0]          br_state_o;
    logic [MW-1:0]       br_dep_mask_o;
    logic                recover_o;
    logic [2:0]          pend_cnt_o;

    br_resolve_sched #(.NUM_BRU(NB), .BR_MASK_W(MW), .BR_STATE_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .bru_valid_i    (bru_valid_i),
        .bru_br_bit_i   (bru_br_bit_i),
        .bru_dep_mask_i (bru_dep_mask_i),
        .bru_wrong_i    (bru_wrong_i),
        .br_state_o     (br_state_o),
        .br_dep_mask_o  (br_dep_mask_o),
        .recover_o      (recover_o),
        .pend_cnt_o     (pend_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    v;
        logic [MW-1:0] b0, d0;
        logic          w0;
        logic [MW-1:0] b1, d1;
        logic          w1;
        logic [1:0]    st;
        logic [MW-1:0] m;
        logic [2:0]    cnt;
    } vec_t;

    localparam logic [1:0] N = BR_NO_BRANCH;
    localparam logic [1:0] C = BR_PR_CORRECT;
    localparam logic [1:0] W = BR_PR_WRONG;

    int total = 0;
    int bad   = 0;
    vec_t vecs [25];

    function automatic vec_t mk(logic [1:0] v, logic [3:0] b0, logic [3:0] d0, logic w0,
                                logic [3:0] b1, logic [3:0] d1, logic w1,
                                logic [1:0] sn, logic [3:0] mn, logic [2:0] cn,
                                logic [1:0] sb, logic [3:0] mb, logic [2:0] cb);
        vec_t r;
        r.v = v; r.b0 = b0; r.d0 = d0; r.w0 = w0; r.b1 = b1; r.d1 = d1; r.w1 = w1;
        r.st  = BYP ? sb : sn;
        r.m   = BYP ? mb : mn;
        r.cnt = BYP ? cb : cn;
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic [1:0] v, logic [3:0] b0, logic [3:0] d0, logic w0,
                         logic [3:0] b1, logic [3:0] d1, logic w1);
        bru_valid_i       = v;
        bru_br_bit_i[0]   = b0;
        bru_dep_mask_i[0] = d0;
        bru_wrong_i[0]    = w0;
        bru_br_bit_i[1]   = b1;
        bru_dep_mask_i[1] = d1;
        bru_wrong_i[1]    = w1;
    endtask

    initial begin
        //             v     b0       d0       w0  b1       d1       w1    normal expect     bypass expect
        vecs[0]  = mk(2'b01, 4'b0010, 4'b0001, 0, 4'b0000, 4'b0000, 0,  N, 4'b0000, 0,  C, 4'b0011, 0);
        vecs[1]  = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  C, 4'b0011, 1,  N, 4'b0000, 0);
        vecs[2]  = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  N, 4'b0000, 0,  N, 4'b0000, 0);
        vecs[3]  = mk(2'b11, 4'b0001, 4'b0000, 0, 4'b0100, 4'b0001, 1,  N, 4'b0000, 0,  C, 4'b0001, 0);
        vecs[4]  = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  W, 4'b0101, 2,  W, 4'b0100, 1);
        vecs[5]  = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  C, 4'b0001, 1,  N, 4'b0000, 0);
        vecs[6]  = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  N, 4'b0000, 0,  N, 4'b0000, 0);
        vecs[7]  = mk(2'b11, 4'b0010, 4'b0000, 1, 4'b1000, 4'b0110, 0,  N, 4'b0000, 0,  W, 4'b0010, 0);
        vecs[8]  = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  W, 4'b0010, 2,  N, 4'b0000, 0);
        vecs[9]  = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  N, 4'b0000, 0,  N, 4'b0000, 0);
        vecs[10] = mk(2'b11, 4'b0001, 4'b0000, 1, 4'b0100, 4'b0001, 1,  N, 4'b0000, 0,  W, 4'b0001, 0);
        vecs[11] = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  W, 4'b0001, 2,  N, 4'b0000, 0);
        vecs[12] = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  N, 4'b0000, 0,  N, 4'b0000, 0);
        vecs[13] = mk(2'b01, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0,  N, 4'b0000, 0,  C, 4'b0001, 0);
        vecs[14] = mk(2'b01, 4'b0010, 4'b0001, 0, 4'b0000, 4'b0000, 0,  C, 4'b0001, 1,  C, 4'b0011, 0);
        vecs[15] = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  C, 4'b0010, 1,  N, 4'b0000, 0);
        vecs[16] = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  N, 4'b0000, 0,  N, 4'b0000, 0);
        vecs[17] = mk(2'b11, 4'b0001, 4'b0000, 1, 4'b0010, 4'b0000, 0,  N, 4'b0000, 0,  W, 4'b0001, 0);
        vecs[18] = mk(2'b11, 4'b0100, 4'b0001, 0, 4'b1000, 4'b0010, 0,  W, 4'b0001, 2,  C, 4'b0010, 1);
        vecs[19] = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  C, 4'b0010, 2,  C, 4'b0101, 2);
        vecs[20] = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  C, 4'b1000, 1,  C, 4'b1000, 1);
        vecs[21] = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  N, 4'b0000, 0,  N, 4'b0000, 0);
        vecs[22] = mk(2'b10, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0000, 1,  N, 4'b0000, 0,  W, 4'b0010, 0);
        vecs[23] = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  W, 4'b0010, 1,  N, 4'b0000, 0);
        vecs[24] = mk(2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0,  N, 4'b0000, 0,  N, 4'b0000, 0);

        rst = 1'b0;
        drive(2'b00, '0, '0, 0, '0, '0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_state", br_state_o, N);
        check("reset_mask", br_dep_mask_o, 0);
        check("reset_recover", recover_o, 0);
        check("reset_cnt", pend_cnt_o, 0);

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].v, vecs[i].b0, vecs[i].d0, vecs[i].w0, vecs[i].b1, vecs[i].d1, vecs[i].w1);
            #1;
            check($sformatf("row%0d_state", i), br_state_o, vecs[i].st);
            check($sformatf("row%0d_mask", i), br_dep_mask_o, vecs[i].m);
            check($sformatf("row%0d_recover", i), recover_o, (vecs[i].st == W) ? 1 : 0);
            check($sformatf("row%0d_cnt", i), pend_cnt_o, vecs[i].cnt);
            @(negedge clk);
        end

        // Reset while entries are pending: nothing issues during reset and the table empties.
        drive(2'b11, 4'b0001, 4'b0000, 0, 4'b0100, 4'b0001, 0);
        @(negedge clk);
        drive(2'b00, '0, '0, 0, '0, '0, 0);
        #1;
        check("midrst_pre_cnt", pend_cnt_o, BYP ? 1 : 2);
        rst = 1'b0;
        #1;
        check("midrst_state", br_state_o, N);
        check("midrst_recover", recover_o, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_post_cnt", pend_cnt_o, 0);
        check("midrst_post_state", br_state_o, N);
        @(negedge clk);
        #1;
        check("midrst_idle_state", br_state_o, N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
